// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with optional first-word-fall-through read
// Lap-bit pointers give full/empty directly; level and sticky error flags are registered.
module sync_fifo #(
    parameter int BITS  = 32,
    parameter int SIZE  = 16,
    parameter int FWFT  = 0,
    parameter int AF_TH = SIZE - 2,
    parameter int AE_TH = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [BITS-1:0]         wr_data,
    output logic                    wr_full,
    output logic                    wr_almost_full,
    output logic                    wr_overflow,
    input  logic                    rd_en,
    output logic [BITS-1:0]         rd_data,
    output logic                    rd_valid,
    output logic                    rd_empty,
    output logic                    rd_almost_empty,
    output logic                    rd_underflow,
    output logic [$clog2(SIZE):0]   level
);

    localparam int          AW     = $clog2(SIZE);
    localparam logic [AW:0] LP_ONE = (AW+1)'(1);
    localparam logic [AW:0] LP_AF  = (AW+1)'(AF_TH);
    localparam logic [AW:0] LP_AE  = (AW+1)'(AE_TH);

    logic [BITS-1:0] r_mem [SIZE];
    logic [AW:0]     r_wptr;
    logic [AW:0]     r_rptr;
    logic [AW:0]     r_level;
    logic            r_overflow;
    logic            r_underflow;

    logic            w_full;
    logic            w_empty;
    logic            w_wr_acc;
    logic            w_rd_acc;
    logic [BITS-1:0] w_head;

    assign w_empty  = (r_wptr == r_rptr);
    assign w_full   = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
    assign w_wr_acc = wr_en && !w_full;
    assign w_rd_acc = rd_en && !w_empty;
    assign w_head   = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_wr_acc) r_wptr <= r_wptr + LP_ONE;
            if (w_rd_acc) r_rptr <= r_rptr + LP_ONE;
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_level <= r_level + LP_ONE;
                2'b01:   r_level <= r_level - LP_ONE;
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage is never cleared; reset only forgets it by zeroing the pointers.
    always_ff @(posedge clk) begin
        if (!rst && w_wr_acc) r_mem[r_wptr[AW-1:0]] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (wr_en && w_full)  r_overflow  <= 1'b1;
            if (rd_en && w_empty) r_underflow <= 1'b1;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign rd_data  = w_head;
            assign rd_valid = !w_empty;
        end else begin : g_std
            logic [BITS-1:0] r_rd_data;
            logic            r_rd_valid;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_rd_data  <= '0;
                    r_rd_valid <= 1'b0;
                end else begin
                    r_rd_valid <= w_rd_acc;
                    if (w_rd_acc) r_rd_data <= w_head;
                end
            end

            assign rd_data  = r_rd_data;
            assign rd_valid = r_rd_valid;
        end
    endgenerate

    assign wr_full         = w_full;
    assign rd_empty        = w_empty;
    assign level           = r_level;
    assign wr_almost_full  = (r_level >= LP_AF);
    assign rd_almost_empty = (r_level <= LP_AE);
    assign wr_overflow     = r_overflow;
    assign rd_underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo.sv
// tb/tb_sync_fifo.sv - directed bench for sync_fifo in standard and FWFT read modes
module tb_sync_fifo;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        wr_en = 1'b0;
    logic [31:0] wr_data = '0;
    logic        rd_en = 1'b0;
    logic        wr_full, wr_almost_full, wr_overflow;
    logic [31:0] rd_data;
    logic        rd_valid, rd_empty, rd_almost_empty, rd_underflow;
    logic [4:0]  level;

    logic        f_wr_en = 1'b0;
    logic [7:0]  f_wr_data = '0;
    logic        f_rd_en = 1'b0;
    logic        f_wr_full, f_wr_almost_full, f_wr_overflow;
    logic [7:0]  f_rd_data;
    logic        f_rd_valid, f_rd_empty, f_rd_almost_empty, f_rd_underflow;
    logic [2:0]  f_level;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    sync_fifo #(.BITS(32), .SIZE(16), .FWFT(0)) u_dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_data(wr_data),
        .wr_full(wr_full), .wr_almost_full(wr_almost_full), .wr_overflow(wr_overflow),
        .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
        .rd_empty(rd_empty), .rd_almost_empty(rd_almost_empty), .rd_underflow(rd_underflow),
        .level(level)
    );

    sync_fifo #(.BITS(8), .SIZE(4), .FWFT(1)) u_dut_fwft (
        .clk(clk), .rst(rst),
        .wr_en(f_wr_en), .wr_data(f_wr_data),
        .wr_full(f_wr_full), .wr_almost_full(f_wr_almost_full), .wr_overflow(f_wr_overflow),
        .rd_en(f_rd_en), .rd_data(f_rd_data), .rd_valid(f_rd_valid),
        .rd_empty(f_rd_empty), .rd_almost_empty(f_rd_almost_empty), .rd_underflow(f_rd_underflow),
        .level(f_level)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle; outputs are then sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_empty", rd_empty, 1);
        check("rst_aempty", rd_almost_empty, 1);
        check("rst_full", wr_full, 0);
        check("rst_afull", wr_almost_full, 0);
        check("rst_level", level, 0);
        check("rst_valid", rd_valid, 0);
        check("rst_data", rd_data, 0);
        check("rst_ovf", wr_overflow, 0);
        check("rst_unf", rd_underflow, 0);
        check("f_rst_valid", f_rd_valid, 0);

        f_wr_en = 1'b1; f_wr_data = 8'h3C;
        tick();
        f_wr_en = 1'b0;
        check("f_data_3c", f_rd_data, 8'h3C);
        check("f_valid_1", f_rd_valid, 1);
        f_wr_en = 1'b1; f_wr_data = 8'h5A;
        tick();
        f_wr_en = 1'b0;
        check("f_head_hold", f_rd_data, 8'h3C);
        check("f_level_2", f_level, 2);
        f_rd_en = 1'b1;
        tick();
        check("f_pop_data", f_rd_data, 8'h5A);
        check("f_pop_level", f_level, 1);
        tick();
        f_rd_en = 1'b0;
        check("f_drain_valid", f_rd_valid, 0);
        check("f_drain_empty", f_rd_empty, 1);

        for (int i = 1; i <= 16; i++) begin
            wr_en = 1'b1; wr_data = i;
            tick();
            check("fill_level", level, i);
            check("fill_afull", wr_almost_full, (i >= 14) ? 1 : 0);
            check("fill_full", wr_full, (i == 16) ? 1 : 0);
            if (i <= 2) check("fill_aempty", rd_almost_empty, (i == 1) ? 1 : 0);
        end

        wr_data = 32'hDEAD;
        tick();
        wr_en = 1'b0;
        check("ovf_set", wr_overflow, 1);
        check("ovf_level", level, 16);
        check("ovf_full", wr_full, 1);
        tick();
        check("ovf_sticky", wr_overflow, 1);

        wr_en = 1'b1; rd_en = 1'b1; wr_data = 32'hBEEF;
        tick();
        wr_en = 1'b0;
        check("fullrw_data", rd_data, 1);
        check("fullrw_valid", rd_valid, 1);
        check("fullrw_level", level, 15);
        for (int k = 2; k <= 16; k++) begin
            tick();
            check("drain_data", rd_data, k);
            check("drain_valid", rd_valid, 1);
        end
        rd_en = 1'b0;
        check("drain_level", level, 0);
        check("drain_empty", rd_empty, 1);
        tick();
        check("idle_valid", rd_valid, 0);
        check("idle_hold", rd_data, 16);

        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("unf_set", rd_underflow, 1);
        check("unf_valid", rd_valid, 0);
        check("unf_level", level, 0);

        wr_en = 1'b1; wr_data = 32'hA5;
        tick();
        wr_en = 1'b0; rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("a5_data", rd_data, 32'hA5);
        check("a5_valid", rd_valid, 1);
        check("a5_empty", rd_empty, 1);
        check("a5_level", level, 0);
        tick();
        check("a5_valid_off", rd_valid, 0);

        for (int k = 0; k < 8; k++) begin
            wr_en = 1'b1; wr_data = 32'h100 + k;
            tick();
        end
        check("pre_rw_level", level, 8);
        rd_en = 1'b1;
        for (int c = 0; c < 40; c++) begin
            wr_data = 32'h108 + c;
            tick();
            check("rw_data", rd_data, 32'h100 + c);
            check("rw_level", level, 8);
        end
        wr_en = 1'b0; rd_en = 1'b0;

        rd_en = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        rd_en = 1'b0;
        check("pre_rst_level", level, 5);
        check("pre_rst_unf", rd_underflow, 1);
        check("pre_rst_ovf", wr_overflow, 1);
        rst = 1'b1; wr_en = 1'b1; rd_en = 1'b1; wr_data = 32'h77;
        tick();
        rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        check("mid_rst_level", level, 0);
        check("mid_rst_empty", rd_empty, 1);
        check("mid_rst_ovf", wr_overflow, 0);
        check("mid_rst_unf", rd_underflow, 0);
        check("mid_rst_valid", rd_valid, 0);
        check("mid_rst_data", rd_data, 0);
        tick();
        check("post_rst_level", level, 0);
        check("post_rst_empty", rd_empty, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
